multicycle_control_unit: RTL

- Multi-cycle successor to the single-cycle KGP-RISC decoder: an FSM sequencing FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK per instruction.
- Drives the shared-memory datapath with per-state control strobes.
- Handles variable-latency memory via a ready handshake with timeout.
- Flags illegal opcodes and pulses an instruction-retired strobe.

---
 rtl/multicycle_control_unit.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control_unit.sv
// Purpose : multi-cycle KGP-RISC control FSM (FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK).
// Latency : mem_ready_i held high: ALU 4, lw 5, sw 4, b/br 3, bl 4 cycles from FETCH to retirement.
// Backpr. : FETCH/MEMORY stall on mem_ready_i; MAX_WAIT idle cycles raise mem_timeout_o (FETCH retries, MEMORY aborts).
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   op_i                opcode field of IR, sampled in DECODE
//   mem_ready_i         memory completes the current access this cycle
//   instr_fetch_o, ir_write_o, pc_write_o, branch_o, ALUop_o, mem_read_o, mem_write_o,
//   alu_source_o, write_into_o, mem_reg_PC_o, reg_write_o   datapath control strobes
//   illegal_op_o, mem_timeout_o, instr_done_o               one-cycle status pulses
module multicycle_control_unit #(
  parameter int OP_W     = 6,
  parameter int ALUOP_W  = 4,
  parameter int MAX_WAIT = 15,
  parameter int WAIT_W   = $clog2(MAX_WAIT + 1)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [OP_W-1:0]    op_i,
  input  logic               mem_ready_i,
  output logic               instr_fetch_o,
  output logic               ir_write_o,
  output logic               pc_write_o,
  output logic [1:0]         branch_o,
  output logic [ALUOP_W-1:0] ALUop_o,
  output logic               mem_read_o,
  output logic               mem_write_o,
  output logic               alu_source_o,
  output logic [1:0]         write_into_o,
  output logic [1:0]         mem_reg_PC_o,
  output logic               reg_write_o,
  output logic               illegal_op_o,
  output logic               mem_timeout_o,
  output logic               instr_done_o
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK
  } state_t;

  localparam logic [OP_W-1:0] OP_ALU1 = OP_W'(1);
  localparam logic [OP_W-1:0] OP_ALU2 = OP_W'(2);
  localparam logic [OP_W-1:0] OP_ALU3 = OP_W'(3);
  localparam logic [OP_W-1:0] OP_ALU4 = OP_W'(4);
  localparam logic [OP_W-1:0] OP_LW   = OP_W'(5);
  localparam logic [OP_W-1:0] OP_SW   = OP_W'(7);
  localparam logic [OP_W-1:0] OP_B    = OP_W'(8);
  localparam logic [OP_W-1:0] OP_BR   = OP_W'(9);
  localparam logic [OP_W-1:0] OP_BL   = OP_W'(10);
  localparam logic [OP_W-1:0] OP_ALUB = OP_W'(11);

  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  state_t            state_q, state_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [WAIT_W-1:0] wait_q, wait_d;

  function automatic logic is_legal(input logic [OP_W-1:0] o);
    case (o)
      OP_ALU1, OP_ALU2, OP_ALU3, OP_ALU4, OP_LW, OP_SW,
      OP_B, OP_BR, OP_BL, OP_ALUB: is_legal = 1'b1;
      default:                     is_legal = 1'b0;
    endcase
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    wait_d        = '0;  // only a stalled FETCH/MEMORY keeps counting
    instr_fetch_o = 1'b0;
    ir_write_o    = 1'b0;
    pc_write_o    = 1'b0;
    branch_o      = 2'b00;
    ALUop_o       = '0;
    mem_read_o    = 1'b0;
    mem_write_o   = 1'b0;
    alu_source_o  = 1'b0;
    write_into_o  = 2'b00;
    mem_reg_PC_o  = 2'b00;
    reg_write_o   = 1'b0;
    illegal_op_o  = 1'b0;
    mem_timeout_o = 1'b0;
    instr_done_o  = 1'b0;

    case (state_q)
      S_FETCH: begin
        instr_fetch_o = 1'b1;
        mem_read_o    = 1'b1;
        if (mem_ready_i) begin
          ir_write_o = 1'b1;
          pc_write_o = 1'b1;
          state_d    = S_DECODE;
        end else if (wait_q == WAIT_MAX) begin
          mem_timeout_o = 1'b1;  // retry the fetch with a fresh budget
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end

      S_DECODE: begin
        // op_q is not yet valid here, so legality is judged on the live field.
        op_d = op_i;
        if (is_legal(op_i)) begin
          state_d = S_EXECUTE;
        end else begin
          illegal_op_o = 1'b1;
          state_d      = S_FETCH;
        end
      end

      S_EXECUTE: begin
        state_d = S_WRITEBACK;
        case (op_q)
          OP_ALU1: ALUop_o = ALUOP_W'(1);
          OP_ALU2: begin ALUop_o = ALUOP_W'(2); alu_source_o = 1'b1; end
          OP_ALU3: ALUop_o = ALUOP_W'(3);
          OP_ALU4: begin ALUop_o = ALUOP_W'(4); alu_source_o = 1'b1; end
          OP_LW:   begin ALUop_o = ALUOP_W'(5); alu_source_o = 1'b1; state_d = S_MEMORY; end
          OP_SW:   begin ALUop_o = ALUOP_W'(6); alu_source_o = 1'b1; state_d = S_MEMORY; end
          OP_B: begin
            ALUop_o = ALUOP_W'(7); branch_o = 2'b01;
            instr_done_o = 1'b1; state_d = S_FETCH;
          end
          OP_BR: begin
            branch_o = 2'b10;
            instr_done_o = 1'b1; state_d = S_FETCH;
          end
          OP_BL:   begin ALUop_o = ALUOP_W'(9); branch_o = 2'b01; end
          OP_ALUB: ALUop_o = ALUOP_W'(10);
          default: state_d = S_FETCH;
        endcase
      end

      S_MEMORY: begin
        // Address computation stays on the ALU for the whole access.
        alu_source_o = 1'b1;
        ALUop_o      = (op_q == OP_LW) ? ALUOP_W'(5) : ALUOP_W'(6);
        mem_read_o   = (op_q == OP_LW);
        mem_write_o  = (op_q != OP_LW);
        if (mem_ready_i) begin
          if (op_q == OP_LW) begin
            state_d = S_WRITEBACK;
          end else begin
            instr_done_o = 1'b1;
            state_d      = S_FETCH;
          end
        end else if (wait_q == WAIT_MAX) begin
          mem_timeout_o = 1'b1;  // abandon the instruction, no retirement
          state_d       = S_FETCH;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end

      S_WRITEBACK: begin
        reg_write_o  = 1'b1;
        instr_done_o = 1'b1;
        state_d      = S_FETCH;
        if (op_q == OP_LW) begin
          write_into_o = 2'b10;
          mem_reg_PC_o = 2'b00;
        end else if (op_q == OP_BL) begin
          write_into_o = 2'b11;
          mem_reg_PC_o = 2'b11;
        end else begin
          write_into_o = 2'b01;
          mem_reg_PC_o = 2'b01;
        end
      end

      default: state_d = S_FETCH;
    endcase

    // Nothing leaves the block while reset is asserted, whatever the state.
    if (rst_i) begin
      instr_fetch_o = 1'b0;
      ir_write_o    = 1'b0;
      pc_write_o    = 1'b0;
      branch_o      = 2'b00;
      ALUop_o       = '0;
      mem_read_o    = 1'b0;
      mem_write_o   = 1'b0;
      alu_source_o  = 1'b0;
      write_into_o  = 2'b00;
      mem_reg_PC_o  = 2'b00;
      reg_write_o   = 1'b0;
      illegal_op_o  = 1'b0;
      mem_timeout_o = 1'b0;
      instr_done_o  = 1'b0;
    end
  end

endmodule
